mem_to_axi4_master: RTL and testbench

- Bridges the core-side memop/memaddr/membyteselect/memrdy memory port to an AXI4 master.
- It is the initiator end of the AXI4 slave bridges in this codebase, so a core can reach AXI slaves such as the SD card bridge.
- It issues one single-beat 32-bit transaction per core request, including exclusive (locked) accesses.
- Only one transaction is outstanding at a time.

---
 rtl/mem_to_axi4_master_pkg.sv | 33 +++
 rtl/mem_to_axi4_master.sv | 202 ++++++++++++++++++++
 tb/tb_mem_to_axi4_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_to_axi4_master_pkg.sv
// Shared definitions for the core-memory-port to AXI4 master bridge:
// response codes, fixed transaction attributes and the controller state encoding.
package mem_to_axi4_master_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [7:0] LEN_SINGLE    = 8'd0;
   localparam logic [2:0] SIZE_4B       = 3'b010;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RADDR,
      ST_RDATA,
      ST_WADDRDATA,
      ST_WRESP
   } state_e;

   // Both SLVERR and DECERR have the upper response bit set.
   function automatic logic resp_is_error(input logic [1:0] resp);
      return resp[1];
   endfunction

   function automatic logic resp_is_exokay(input logic [1:0] resp);
      return resp == RESP_EXOKAY;
   endfunction

endpackage

// File: rtl/mem_to_axi4_master.sv
// Bridges the core memop/memaddr/memrdy port to a single-outstanding AXI4 master.
// Every request becomes one 32-bit single-beat transaction, optionally exclusive.
module mem_to_axi4_master
   import mem_to_axi4_master_pkg::*;
#(
   parameter int          C_M_AXI_ID_WIDTH      = 4,
   parameter int          C_M_AXI_ADDR_WIDTH    = 32,
   parameter int          C_M_AXI_DATA_WIDTH    = 32,
   parameter int          C_M_AXI_ID            = 0,
   parameter logic [31:0] C_M_AXI_MEM0_BASEADDR = 32'h00000000
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic [1:0]                    memop,
   input  logic                          memlock,
   input  logic [C_M_AXI_ADDR_WIDTH-3:0] memaddr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] memdatain,
   input  logic [3:0]                    membyteselect,
   output logic [C_M_AXI_DATA_WIDTH-1:0] memdataout,
   output logic                          memrdy,
   output logic                          memerr,
   output logic                          memexok,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARLOCK,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic [2:0]                    M_AXI_ARPROT,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
   input  logic                          M_AXI_RLAST,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
   output logic [7:0]                    M_AXI_AWLEN,
   output logic [2:0]                    M_AXI_AWSIZE,
   output logic [1:0]                    M_AXI_AWBURST,
   output logic                          M_AXI_AWLOCK,
   output logic [3:0]                    M_AXI_AWCACHE,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WLAST,
   output logic                          M_AXI_BREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID
);

   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = C_M_AXI_ADDR_WIDTH'(C_M_AXI_MEM0_BASEADDR);
   localparam logic [C_M_AXI_ID_WIDTH-1:0]   AXI_ID    = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);

   state_e                          state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [3:0]                      wstrb_q, wstrb_d;
   logic                            lock_q, lock_d;
   logic                            aw_done_q, aw_done_d;
   logic                            w_done_q, w_done_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                            err_q, err_d;
   logic                            exok_q, exok_d;

   // IDs and RLAST carry no information for a single-outstanding, single-beat master.
   logic unused_inputs;
   assign unused_inputs = ^{M_AXI_RID, M_AXI_RLAST, M_AXI_BID};

   // State and captured request/response registers; reset abandons any transaction.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         lock_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         exok_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         lock_q    <= lock_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         exok_q    <= exok_d;
      end
   end

   // Next-state logic: accept in IDLE, walk the AXI handshakes, latch the response.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      lock_d    = lock_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      exok_d    = exok_q;
      case (state_q)
         ST_IDLE: begin
            if (memop != 2'b00) begin
               state_d   = memop[1] ? ST_RADDR : ST_WADDRDATA;
               addr_d    = {memaddr, 2'b00} + BASE_ADDR;
               wdata_d   = memdatain;
               wstrb_d   = membyteselect;
               lock_d    = memlock;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         ST_RADDR: begin
            if (M_AXI_ARREADY) begin
               state_d = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (M_AXI_RVALID) begin
               rdata_d = M_AXI_RDATA;
               err_d   = resp_is_error(M_AXI_RRESP);
               exok_d  = resp_is_exokay(M_AXI_RRESP);
               state_d = ST_IDLE;
            end
         end
         ST_WADDRDATA: begin
            if (M_AXI_AWREADY) begin
               aw_done_d = 1'b1;
            end
            if (M_AXI_WREADY) begin
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d = ST_WRESP;
            end
         end
         ST_WRESP: begin
            if (M_AXI_BVALID) begin
               err_d   = resp_is_error(M_AXI_BRESP);
               exok_d  = resp_is_exokay(M_AXI_BRESP);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the current state and the write-pair flags.
   always_comb begin
      memrdy        = (state_q == ST_IDLE);
      M_AXI_ARVALID = (state_q == ST_RADDR);
      M_AXI_RREADY  = (state_q == ST_RDATA);
      M_AXI_AWVALID = (state_q == ST_WADDRDATA) && !aw_done_q;
      M_AXI_WVALID  = (state_q == ST_WADDRDATA) && !w_done_q;
      M_AXI_BREADY  = (state_q == ST_WRESP);
   end

   assign memdataout    = rdata_q;
   assign memerr        = err_q;
   assign memexok       = exok_q;

   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARID    = AXI_ID;
   assign M_AXI_ARLEN   = LEN_SINGLE;
   assign M_AXI_ARSIZE  = SIZE_4B;
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_ARLOCK  = lock_q;
   assign M_AXI_ARCACHE = CACHE_DEFAULT;
   assign M_AXI_ARPROT  = PROT_DEFAULT;

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWID    = AXI_ID;
   assign M_AXI_AWLEN   = LEN_SINGLE;
   assign M_AXI_AWSIZE  = SIZE_4B;
   assign M_AXI_AWBURST = BURST_INCR;
   assign M_AXI_AWLOCK  = lock_q;
   assign M_AXI_AWCACHE = CACHE_DEFAULT;
   assign M_AXI_AWPROT  = PROT_DEFAULT;

   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WLAST   = 1'b1;

endmodule

// File: tb/tb_mem_to_axi4_master.sv
// Self-checking bench for mem_to_axi4_master: a scripted AXI slave with random
// handshake delays, plus a transaction-level model of the core-visible results.
module tb_mem_to_axi4_master;

   localparam logic [31:0] BASE   = 32'h40000000;
   localparam int          AXI_ID = 5;
   localparam logic [31:0] ATTRS  = {8'h00, 3'b010, 2'b01, 4'b0011, 3'b000, 4'h5, 8'h00};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  memop = 2'b00;
   logic        memlock = 1'b0;
   logic [29:0] memaddr = '0;
   logic [31:0] memdatain = '0;
   logic [3:0]  membyteselect = '0;
   logic [31:0] memdataout;
   logic        memrdy, memerr, memexok;

   logic [31:0] araddr, awaddr, rdata, wdata;
   logic        arvalid, arready, rvalid, rready, rlast, arlock, awlock;
   logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
   logic [3:0]  arid, awid, rid, bid, arcache, awcache, wstrb;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, rresp, bresp;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl_dataout = '0;
   logic        mdl_err = 1'b0;
   logic        mdl_exok = 1'b0;

   mem_to_axi4_master #(
      .C_M_AXI_ID_WIDTH(4), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ID(AXI_ID), .C_M_AXI_MEM0_BASEADDR(BASE)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .memop(memop), .memlock(memlock), .memaddr(memaddr), .memdatain(memdatain),
      .membyteselect(membyteselect), .memdataout(memdataout), .memrdy(memrdy),
      .memerr(memerr), .memexok(memexok),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_ARID(arid), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
      .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
      .M_AXI_RDATA(rdata), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .M_AXI_RRESP(rresp), .M_AXI_RID(rid), .M_AXI_RLAST(rlast),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_AWID(awid), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
      .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
      .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BID(bid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Runs one core request against the scripted slave; called at a negedge with
   // memrdy expected high, returns at the negedge where memrdy is back.
   task automatic applyStimulus(input logic [1:0] op, input logic lock, input logic [29:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                input logic [1:0] resp, input logic [31:0] rd,
                                input int d_addr, input int d_w, input int d_resp);
      logic [31:0] exp_addr;
      logic [31:0] rnd;
      bit          is_read, a_done, w_done, r_done, finished;
      int          a_cyc, w_cyc, resp_cyc, cyc;
      is_read  = op[1];
      exp_addr = {addr, 2'b00} + BASE;
      checkOutput("memrdy_before_req", 32'(memrdy), 32'd1);
      memop = op; memlock = lock; memaddr = addr; memdatain = data; membyteselect = strb;
      @(negedge clk);
      rnd = $urandom();
      memop = 2'b00; memaddr = rnd[29:0]; memdatain = $urandom(); membyteselect = rnd[7:4]; memlock = rnd[8];
      a_done = 0; w_done = 0; r_done = 0; finished = 0;
      a_cyc = 0; w_cyc = 0; resp_cyc = 0; cyc = 0;
      while (!finished && cyc < 200) begin
         if (r_done) begin
            rvalid = 1'b0; bvalid = 1'b0;
            checkOutput("memrdy_after_resp", 32'(memrdy), 32'd1);
            finished = 1;
         end else begin
            checkOutput("memrdy_busy", 32'(memrdy), 32'd0);
            checkOutput("dataout_stable", memdataout, mdl_dataout);
            if (is_read) begin
               checkOutput("no_write_on_read", 32'({awvalid, wvalid, bready}), 32'd0);
               if (!a_done) begin
                  checkOutput("arvalid", 32'(arvalid), 32'd1);
                  checkOutput("araddr", araddr, exp_addr);
                  checkOutput("arlock", 32'(arlock), 32'(lock));
                  checkOutput("ar_attrs", {arlen, arsize, arburst, arcache, arprot, arid, 8'h00}, ATTRS);
                  checkOutput("rready_before_ar", 32'(rready), 32'd0);
                  arready = (a_cyc >= d_addr);
                  a_done  = arready;
                  a_cyc++;
               end else begin
                  arready = 1'b0;
                  checkOutput("arvalid_dropped", 32'(arvalid), 32'd0);
                  checkOutput("rready", 32'(rready), 32'd1);
                  rnd = $urandom();
                  if (resp_cyc >= d_resp) begin
                     rvalid = 1'b1; rdata = rd; rresp = resp; rlast = rnd[0]; rid = rnd[4:1];
                     r_done = 1;
                  end else begin
                     rvalid = 1'b0; rdata = rnd;
                  end
                  resp_cyc++;
               end
            end else begin
               checkOutput("no_read_on_write", 32'({arvalid, rready}), 32'd0);
               if (!(a_done && w_done)) begin
                  checkOutput("bready_early", 32'(bready), 32'd0);
                  checkOutput("awvalid", 32'(awvalid), 32'(!a_done));
                  checkOutput("wvalid", 32'(wvalid), 32'(!w_done));
                  if (!a_done) begin
                     checkOutput("awaddr", awaddr, exp_addr);
                     checkOutput("awlock", 32'(awlock), 32'(lock));
                     checkOutput("aw_attrs", {awlen, awsize, awburst, awcache, awprot, awid, 8'h00}, ATTRS);
                     awready = (a_cyc >= d_addr);
                     a_cyc++;
                  end else begin
                     awready = 1'b0;
                  end
                  if (!w_done) begin
                     checkOutput("wdata", wdata, data);
                     checkOutput("wstrb", 32'(wstrb), 32'(strb));
                     checkOutput("wlast", 32'(wlast), 32'd1);
                     wready = (w_cyc >= d_w);
                     w_cyc++;
                  end else begin
                     wready = 1'b0;
                  end
                  a_done = a_done || awready;
                  w_done = w_done || wready;
               end else begin
                  awready = 1'b0; wready = 1'b0;
                  checkOutput("valids_dropped", 32'({awvalid, wvalid}), 32'd0);
                  checkOutput("bready", 32'(bready), 32'd1);
                  rnd = $urandom();
                  if (resp_cyc >= d_resp) begin
                     bvalid = 1'b1; bresp = resp; bid = rnd[3:0];
                     r_done = 1;
                  end else begin
                     bvalid = 1'b0;
                  end
                  resp_cyc++;
               end
            end
            @(negedge clk);
         end
         cyc++;
      end
      arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
      checkOutput("completed_in_budget", 32'(finished), 32'd1);
      if (is_read) mdl_dataout = rd;
      mdl_err  = resp[1];
      mdl_exok = (resp == 2'b01);
      checkOutput("memdataout", memdataout, mdl_dataout);
      checkOutput("memerr", 32'(memerr), 32'(mdl_err));
      checkOutput("memexok", 32'(memexok), 32'(mdl_exok));
   endtask

   initial begin
      logic [31:0] r1, r2;
      logic [1:0]  op;
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      rdata = '0; rresp = '0; rid = '0; rlast = 0; bresp = '0; bid = '0;

      #3;
      checkOutput("reset_memrdy", 32'(memrdy), 32'd1);
      checkOutput("reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
      checkOutput("reset_dataout", memdataout, 32'd0);
      checkOutput("reset_flags", 32'({memerr, memexok}), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(2'b10, 1'b0, 30'h10, 32'h0, 4'hF, 2'b00, 32'hDEADBEEF, 3, 0, 1);
      applyStimulus(2'b01, 1'b0, 30'h24, 32'hA5A5A5A5, 4'b0011, 2'b00, 32'h0, 2, 0, 0);
      applyStimulus(2'b10, 1'b1, 30'h3FFFFFFF, 32'h0, 4'hF, 2'b01, 32'h12345678, 0, 0, 0);
      applyStimulus(2'b01, 1'b1, 30'h3FFFFFFF, 32'hCAFEF00D, 4'b1000, 2'b00, 32'h0, 0, 2, 1);
      applyStimulus(2'b10, 1'b0, 30'h7, 32'h0, 4'hF, 2'b11, 32'h0BADF00D, 1, 0, 2);
      applyStimulus(2'b01, 1'b0, 30'h8, 32'h11112222, 4'hF, 2'b00, 32'h0, 0, 0, 0);
      applyStimulus(2'b11, 1'b0, 30'h100, 32'h0, 4'hF, 2'b00, 32'h55AA55AA, 1, 0, 0);
      applyStimulus(2'b01, 1'b0, 30'h101, 32'h77777777, 4'hF, 2'b10, 32'h0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         r1 = $urandom();
         r2 = $urandom();
         case (r1[1:0])
            2'd0:    op = 2'b01;
            2'd1:    op = 2'b11;
            default: op = r1[2] ? 2'b10 : 2'b01;
         endcase
         if (r1[3]) begin
            repeat (int'(r1[5:4])) begin
               @(negedge clk);
               checkOutput("memrdy_idle_gap", 32'(memrdy), 32'd1);
            end
         end
         applyStimulus(op, r1[6], r2[29:0], $urandom(), r1[10:7], r1[12:11], $urandom(),
                       int'(r1[14:13]), int'(r1[16:15]), int'(r1[18:17]));
      end

      // Abandon a read while waiting for its data, then confirm recovery.
      applyStimulus(2'b10, 1'b0, 30'h20, 32'h0, 4'hF, 2'b11, 32'hFEEDFACE, 0, 0, 0);
      memop = 2'b10; memaddr = 30'h30;
      @(negedge clk);
      memop = 2'b00; arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      checkOutput("rready_before_reset", 32'(rready), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
      checkOutput("reset_mid_memrdy", 32'(memrdy), 32'd1);
      checkOutput("reset_mid_dataout", memdataout, 32'd0);
      checkOutput("reset_mid_flags", 32'({memerr, memexok}), 32'd0);
      mdl_dataout = '0; mdl_err = 1'b0; mdl_exok = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("release_memrdy", 32'(memrdy), 32'd1);
      checkOutput("release_dataout", memdataout, 32'd0);
      applyStimulus(2'b10, 1'b0, 30'h44, 32'h0, 4'hF, 2'b00, 32'h89ABCDEF, 1, 0, 1);
      applyStimulus(2'b01, 1'b0, 30'h45, 32'h01020304, 4'b0101, 2'b01, 32'h0, 1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
